traffic_ctrl_param: RTL and testbench

TRAFFIC_CTRL_PARAM -- requirements
Module: traffic_ctrl_param

---
 rtl/traffic_ctrl_param.sv | 135 +++++++++++++
 tb/tb_traffic_ctrl_param.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_param.sv
// Two-way intersection controller with a pedestrian walk phase and a flashing-yellow night mode.
// Phase lengths are counted in timebase ticks, so the controller is independent of the clock rate.
module traffic_ctrl_param #(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 3,
    parameter int CW           = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic ped_req,
    input  logic flash_en,
    output logic ns_g,
    output logic ns_y,
    output logic ns_r,
    output logic ew_g,
    output logic ew_y,
    output logic ew_r,
    output logic walk,
    output logic ped_pending
);

    localparam logic [2:0] S_NS_G  = 3'd0;
    localparam logic [2:0] S_NS_Y  = 3'd1;
    localparam logic [2:0] S_AR1   = 3'd2;
    localparam logic [2:0] S_EW_G  = 3'd3;
    localparam logic [2:0] S_EW_Y  = 3'd4;
    localparam logic [2:0] S_AR2   = 3'd5;
    localparam logic [2:0] S_WALK  = 3'd6;
    localparam logic [2:0] S_FLASH = 3'd7;

    localparam logic [CW-1:0] G_LAST = CW'(GREEN_TICKS - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_TICKS - 1);
    localparam logic [CW-1:0] A_LAST = CW'(ALLRED_TICKS - 1);
    localparam logic [CW-1:0] W_LAST = CW'(WALK_TICKS - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] lastCnt;
    logic [2:0]    nextPhase;

    // Final count value and successor of each timed phase.
    always_comb begin
        lastCnt   = '0;
        nextPhase = S_NS_G;
        case (state_q)
            S_NS_G: begin lastCnt = G_LAST; nextPhase = S_NS_Y; end
            S_NS_Y: begin lastCnt = Y_LAST; nextPhase = S_AR1;  end
            S_AR1:  begin lastCnt = A_LAST; nextPhase = S_EW_G; end
            S_EW_G: begin lastCnt = G_LAST; nextPhase = S_EW_Y; end
            S_EW_Y: begin lastCnt = Y_LAST; nextPhase = S_AR2;  end
            S_AR2:  begin lastCnt = A_LAST; nextPhase = pend_q ? S_WALK : S_NS_G; end
            S_WALK: begin lastCnt = W_LAST; nextPhase = S_NS_G; end
            default: begin lastCnt = '0; nextPhase = S_NS_G; end
        endcase
    end

    // Flash mode overrides phase timing; leaving it restarts from the second all-red.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (state_q == S_FLASH) begin
            if (!flash_en) begin
                state_d = S_AR2;
                cnt_d   = '0;
                blink_d = 1'b0;
            end else if (tick) begin
                blink_d = ~blink_q;
            end
        end else if (flash_en) begin
            state_d = S_FLASH;
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (tick) begin
            if (cnt_q == lastCnt) begin
                state_d = nextPhase;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A request arriving on the cycle the walk phase starts is considered served by it.
    always_comb begin
        pend_d = pend_q;
        if (ped_req && state_q != S_WALK) begin
            pend_d = 1'b1;
        end
        if (state_d == S_WALK && state_q != S_WALK) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_NS_G;
            cnt_q   <= '0;
            blink_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        ns_g = 1'b0;
        ns_y = 1'b0;
        ns_r = 1'b0;
        ew_g = 1'b0;
        ew_y = 1'b0;
        ew_r = 1'b0;
        walk = 1'b0;
        case (state_q)
            S_NS_G:  begin ns_g = 1'b1; ew_r = 1'b1; end
            S_NS_Y:  begin ns_y = 1'b1; ew_r = 1'b1; end
            S_EW_G:  begin ns_r = 1'b1; ew_g = 1'b1; end
            S_EW_Y:  begin ns_r = 1'b1; ew_y = 1'b1; end
            S_WALK:  begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
            S_FLASH: begin ns_y = blink_q; ew_y = blink_q; end
            default: begin ns_r = 1'b1; ew_r = 1'b1; end
        endcase
    end

    assign ped_pending = pend_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Directed bench for traffic_ctrl_param: default timing, pedestrian service, flash mode,
// tick stalls, reset priority and an overridden-timing instance.
module tb_traffic_ctrl_param;

    logic clk = 1'b0;
    logic rst, tick, ped_req, flash_en;
    logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_pending;
    logic ns_g2, ns_y2, ns_r2, ew_g2, ew_y2, ew_r2, walk2, ped_pending2;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] L_NS_G  = 7'b1000010;
    localparam logic [6:0] L_NS_Y  = 7'b0100010;
    localparam logic [6:0] L_AR    = 7'b0010010;
    localparam logic [6:0] L_EW_G  = 7'b0011000;
    localparam logic [6:0] L_EW_Y  = 7'b0010100;
    localparam logic [6:0] L_WALK  = 7'b0010011;
    localparam logic [6:0] L_FL_ON = 7'b0100100;
    localparam logic [6:0] L_DARK  = 7'b0000000;

    always #5 clk = ~clk;

    traffic_ctrl_param dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
        .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
        .walk(walk), .ped_pending(ped_pending)
    );

    traffic_ctrl_param #(.GREEN_TICKS(3), .YELLOW_TICKS(1), .ALLRED_TICKS(2)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
        .ns_g(ns_g2), .ns_y(ns_y2), .ns_r(ns_r2), .ew_g(ew_g2), .ew_y(ew_y2), .ew_r(ew_r2),
        .walk(walk2), .ped_pending(ped_pending2)
    );

    wire [6:0] lamps  = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};
    wire [6:0] lamps2 = {ns_g2, ns_y2, ns_r2, ew_g2, ew_y2, ew_r2, walk2};

    // Expected lamps k tick-edges after reset for a request-free cycle of the given phase lengths.
    function automatic logic [6:0] cycleLamps(int k, int g, int y, int a);
        int p;
        p = k % (2 * (g + y + a));
        if (p < g)                 return L_NS_G;
        if (p < g + y)             return L_NS_Y;
        if (p < g + y + a)         return L_AR;
        if (p < 2 * g + y + a)     return L_EW_G;
        if (p < 2 * g + 2 * y + a) return L_EW_Y;
        return L_AR;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic t, input logic p, input logic f);
        rst      = r;
        tick     = t;
        ped_req  = p;
        flash_en = f;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; ped_req = 1'b0; flash_en = 1'b0;

        // Reset state, including reset winning over other inputs.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("reset_lamps", 32'(lamps), 32'(L_NS_G));
        checkOutput("reset_pending", 32'(ped_pending), 32'd0);
        doReset();
        checkOutput("reset_lamps2", 32'(lamps), 32'(L_NS_G));

        // Default timing, tick every cycle, two full periods.
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("cycle_k%0d", k), 32'(lamps), 32'(cycleLamps(k, 5, 2, 1)));
        end

        // Pedestrian request during EW_G.
        doReset();
        for (int k = 1; k <= 19; k++) begin
            applyStimulus(1'b0, 1'b1, k == 10, 1'b0);
            checkOutput($sformatf("ped_lamps_k%0d", k), 32'(lamps),
                        32'((k >= 16 && k <= 18) ? L_WALK : cycleLamps(k, 5, 2, 1)));
            checkOutput($sformatf("ped_pend_k%0d", k), 32'(ped_pending), 32'(k >= 10 && k <= 15));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("ped_after_walk", 32'(lamps), 32'(L_NS_G));

        // Flash mode entered mid NS_G without a tick.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("flash_enter", 32'(lamps), 32'(L_DARK));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("flash_hold", 32'(lamps), 32'(L_DARK));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("flash_on1", 32'(lamps), 32'(L_FL_ON));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("flash_off1", 32'(lamps), 32'(L_DARK));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("flash_on2", 32'(lamps), 32'(L_FL_ON));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("flash_exit_ar2", 32'(lamps), 32'(L_AR));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("flash_exit_nsg", 32'(lamps), 32'(L_NS_G));

        // Pending request survives flash and is served after the exit all-red.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("flpend_set", 32'(ped_pending), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("flpend_in_flash", 32'(ped_pending), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("flpend_ar2", 32'(lamps), 32'(L_AR));
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("flpend_walk", 32'(lamps), 32'(L_WALK));
        checkOutput("flpend_absorbed", 32'(ped_pending), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("walk_req_ignored", 32'(ped_pending), 32'd0);

        // Stall in EW_Y with cnt=1.
        doReset();
        for (int k = 1; k <= 14; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_start", 32'(lamps), 32'(L_EW_Y));
        for (int k = 0; k < 50; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (k % 10 == 9) checkOutput($sformatf("stall_%0d", k), 32'(lamps), 32'(L_EW_Y));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("stall_release", 32'(lamps), 32'(L_AR));

        // Reset during WALK with request and flash asserted.
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 2; k <= 16; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rstwalk_in_walk", 32'(lamps), 32'(L_WALK));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("rstwalk_lamps", 32'(lamps), 32'(L_NS_G));
        checkOutput("rstwalk_pending", 32'(ped_pending), 32'd0);
        for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rstwalk_cnt_nsg", 32'(lamps), 32'(L_NS_G));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rstwalk_cnt_nsy", 32'(lamps), 32'(L_NS_Y));

        // Overridden timing instance: 3/1/2 gives a 12-tick period.
        doReset();
        checkOutput("ovr_reset", 32'(lamps2), 32'(L_NS_G));
        for (int k = 1; k <= 24; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("ovr_k%0d", k), 32'(lamps2), 32'(cycleLamps(k, 3, 1, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
